// File: rtl/sram_responder_pkg.sv
// Shared constants for the dual-port SRAM responder: bus widths, default base address, poison word.
package sram_responder_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned BYTES_PER_WORD = DATA_W / 8;

  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 32'hBFC0_0000;
  localparam logic [DATA_W-1:0] POISON_WORD       = 32'hDEAD_BEEF;

endpackage

// File: rtl/sram_dp_array.sv
// Dual-port byte-enabled word array with read-first registered reads and data-port write priority.
module sram_dp_array
  import sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_en,
  input  logic [BYTES_PER_WORD-1:0] inst_we,
  input  logic [DEPTH_LOG2-1:0]     inst_idx,
  input  logic [DATA_W-1:0]         inst_wdata,
  input  logic                      inst_poison,
  output logic [DATA_W-1:0]         inst_rdata,
  input  logic                      data_en,
  input  logic [BYTES_PER_WORD-1:0] data_we,
  input  logic [DEPTH_LOG2-1:0]     data_idx,
  input  logic [DATA_W-1:0]         data_wdata,
  input  logic                      data_poison,
  output logic [DATA_W-1:0]         data_rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Data-port byte lanes are assigned last so they win a same-byte collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < int'(BYTES_PER_WORD); b++) begin
        if (inst_we[b]) mem[inst_idx][8*b +: 8] <= inst_wdata[8*b +: 8];
        if (data_we[b]) mem[data_idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  // Nonblocking reads sample the pre-write word, giving read-first on both ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      if (inst_en) inst_rdata <= inst_poison ? POISON_WORD : mem[inst_idx];
      if (data_en) data_rdata <= data_poison ? POISON_WORD : mem[data_idx];
    end
  end

endmodule

// File: rtl/sram_responder.sv
// SRAM responder: address offset/decode, optional range check (SRAM_RESP_ERR_EN) and sticky error capture.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int unsigned       DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_sram_en,
  input  logic [BYTES_PER_WORD-1:0] inst_sram_wen,
  input  logic [ADDR_W-1:0]         inst_sram_addr,
  input  logic [DATA_W-1:0]         inst_sram_wdata,
  output logic [DATA_W-1:0]         inst_sram_rdata,
  input  logic                      data_sram_en,
  input  logic [BYTES_PER_WORD-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0]         data_sram_addr,
  input  logic [DATA_W-1:0]         data_sram_wdata,
  output logic [DATA_W-1:0]         data_sram_rdata,
  output logic                      err,
  output logic [ADDR_W-1:0]         err_addr
);

  logic [ADDR_W-1:0]         inst_off, data_off;
  logic                      inst_oor, data_oor;
  logic [BYTES_PER_WORD-1:0] inst_we, data_we;

  assign inst_off = inst_sram_addr - BASE_ADDR;
  assign data_off = data_sram_addr - BASE_ADDR;

`ifdef SRAM_RESP_ERR_EN
  localparam logic [ADDR_W-1:0] SPAN_BYTES = ADDR_W'(BYTES_PER_WORD) << DEPTH_LOG2;

  logic unused_off_lsbs;
  assign unused_off_lsbs = ^{inst_off[1:0], data_off[1:0]};

  assign inst_oor = inst_sram_en && (inst_off >= SPAN_BYTES);
  assign data_oor = data_sram_en && (data_off >= SPAN_BYTES);

  // First out-of-range event latches its address; data port wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (!err && (inst_oor || data_oor)) begin
      err      <= 1'b1;
      err_addr <= data_oor ? data_sram_addr : inst_sram_addr;
    end
  end
`else
  logic unused_off_bits;
  assign unused_off_bits = ^{inst_off[ADDR_W-1:DEPTH_LOG2+2], inst_off[1:0],
                             data_off[ADDR_W-1:DEPTH_LOG2+2], data_off[1:0]};

  assign inst_oor = 1'b0;
  assign data_oor = 1'b0;
  assign err      = 1'b0;
  assign err_addr = '0;
`endif

  assign inst_we = (inst_sram_en && !inst_oor) ? inst_sram_wen : '0;
  assign data_we = (data_sram_en && !data_oor) ? data_sram_wen : '0;

  sram_dp_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .inst_en    (inst_sram_en),
    .inst_we    (inst_we),
    .inst_idx   (inst_off[DEPTH_LOG2+1:2]),
    .inst_wdata (inst_sram_wdata),
    .inst_poison(inst_oor),
    .inst_rdata (inst_sram_rdata),
    .data_en    (data_sram_en),
    .data_we    (data_we),
    .data_idx   (data_off[DEPTH_LOG2+1:2]),
    .data_wdata (data_sram_wdata),
    .data_poison(data_oor),
    .data_rdata (data_sram_rdata)
  );

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder; range-check tests follow SRAM_RESP_ERR_EN.
module tb_sram_responder;
  import sram_responder_pkg::*;

  localparam int unsigned DL2  = 10;
  localparam logic [31:0] BASE = 32'hBFC0_0000;
  localparam logic [31:0] SPAN = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en, data_sram_en;
  logic [3:0]  inst_sram_wen, data_sram_wen;
  logic [31:0] inst_sram_addr, data_sram_addr;
  logic [31:0] inst_sram_wdata, data_sram_wdata;
  logic [31:0] inst_sram_rdata, data_sram_rdata;
  logic        err;
  logic [31:0] err_addr;

  int errors = 0;
  int checks = 0;
  logic [31:0] q_i[$];
  logic [31:0] q_d[$];
  logic [31:0] exp;

  sram_responder #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata),
    .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // One request cycle on both ports; returns #1 after the capturing edge.
  task automatic drive(input logic ie, input logic [3:0] iw, input logic [31:0] ia, input logic [31:0] id,
                       input logic de, input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
    inst_sram_en = ie; inst_sram_wen = iw; inst_sram_addr = ia; inst_sram_wdata = id;
    data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
    @(posedge clk);
    #1;
    inst_sram_en = 1'b0; data_sram_en = 1'b0;
    inst_sram_wen = 4'h0; data_sram_wen = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inst_sram_en = 1'b0; data_sram_en = 1'b0;
    inst_sram_wen = 4'h0; data_sram_wen = 4'h0;
    inst_sram_addr = BASE; data_sram_addr = BASE;
    inst_sram_wdata = '0; data_sram_wdata = '0;
    #1;
    checks++; if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset inst_rdata: got %h want 0", inst_sram_rdata); end
    checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL reset data_rdata: got %h want 0", data_sram_rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset err: got %b want 0", err); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL reset err_addr: got %h want 0", err_addr); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    drive(0, 4'h0, BASE, 0, 1, 4'hF, BASE + 32'h10, 32'h1234_5678);
    q_i.push_back(32'h1234_5678);
    drive(1, 4'h0, BASE + 32'h10, 0, 0, 4'h0, BASE, 0);
    exp = q_i.pop_front(); checks++;
    if (inst_sram_rdata !== exp) begin errors++; $display("FAIL write_read inst_rdata: got %h want %h", inst_sram_rdata, exp); end
  endtask

  task automatic test_byte_write();
    drive(1, 4'hF, BASE + 32'h30, 32'hFFFF_FFFF, 0, 4'h0, BASE, 0);
    drive(0, 4'h0, BASE, 0, 1, 4'b0101, BASE + 32'h30, 32'hAABB_CCDD);
    q_d.push_back(32'hFFBB_FFDD);
    drive(0, 4'h0, BASE, 0, 1, 4'h0, BASE + 32'h30, 0);
    exp = q_d.pop_front(); checks++;
    if (data_sram_rdata !== exp) begin errors++; $display("FAIL byte_write data_rdata: got %h want %h", data_sram_rdata, exp); end
    // Idle cycle with wen set: no write, rdata held.
    q_d.push_back(32'hFFBB_FFDD);
    drive(0, 4'h0, BASE, 0, 0, 4'hF, BASE + 32'h30, 32'h0);
    exp = q_d.pop_front(); checks++;
    if (data_sram_rdata !== exp) begin errors++; $display("FAIL hold data_rdata: got %h want %h", data_sram_rdata, exp); end
    q_i.push_back(32'hFFBB_FFDD);
    drive(1, 4'h0, BASE + 32'h30, 0, 0, 4'h0, BASE, 0);
    exp = q_i.pop_front(); checks++;
    if (inst_sram_rdata !== exp) begin errors++; $display("FAIL no_write_when_idle inst_rdata: got %h want %h", inst_sram_rdata, exp); end
  endtask

  task automatic test_read_first();
    drive(0, 4'h0, BASE, 0, 1, 4'hF, BASE + 32'h40, 32'hCAFE_0001);
    q_i.push_back(32'hCAFE_0001);
    q_d.push_back(32'hCAFE_0001);
    drive(1, 4'h0, BASE + 32'h40, 0, 1, 4'hF, BASE + 32'h40, 32'h0);
    exp = q_i.pop_front(); checks++;
    if (inst_sram_rdata !== exp) begin errors++; $display("FAIL cross_read_first inst_rdata: got %h want %h", inst_sram_rdata, exp); end
    exp = q_d.pop_front(); checks++;
    if (data_sram_rdata !== exp) begin errors++; $display("FAIL same_read_first data_rdata: got %h want %h", data_sram_rdata, exp); end
    q_i.push_back(32'h0);
    drive(1, 4'h0, BASE + 32'h40, 0, 0, 4'h0, BASE, 0);
    exp = q_i.pop_front(); checks++;
    if (inst_sram_rdata !== exp) begin errors++; $display("FAIL after_write inst_rdata: got %h want %h", inst_sram_rdata, exp); end
  endtask

  task automatic test_collision();
    drive(1, 4'hF, BASE + 32'h20, 32'h1111_1111, 1, 4'hF, BASE + 32'h20, 32'h2222_2222);
    drive(1, 4'b0011, BASE + 32'h24, 32'h3333_3333, 1, 4'b1100, BASE + 32'h24, 32'h4444_4444);
    q_i.push_back(32'h2222_2222);
    q_d.push_back(32'h4444_3333);
    drive(1, 4'h0, BASE + 32'h20, 0, 1, 4'h0, BASE + 32'h24, 0);
    exp = q_i.pop_front(); checks++;
    if (inst_sram_rdata !== exp) begin errors++; $display("FAIL collision_same_byte inst_rdata: got %h want %h", inst_sram_rdata, exp); end
    exp = q_d.pop_front(); checks++;
    if (data_sram_rdata !== exp) begin errors++; $display("FAIL collision_split_bytes data_rdata: got %h want %h", data_sram_rdata, exp); end
  endtask

  task automatic test_random();
    logic [31:0] model [16];
    logic        ie, de;
    logic [3:0]  iw, dw;
    int unsigned ik, dk;
    logic [31:0] idt, ddt;
    for (int k = 0; k < 16; k++) begin
      model[k] = $urandom;
      drive(0, 4'h0, BASE, 0, 1, 4'hF, BASE + 32'h100 + 32'(4 * k), model[k]);
    end
    for (int n = 0; n < 60; n++) begin
      ie = 1'($urandom_range(0, 1)); de = 1'($urandom_range(0, 1));
      iw = 4'($urandom_range(0, 15)); dw = 4'($urandom_range(0, 15));
      ik = $urandom_range(0, 15); dk = $urandom_range(0, 15);
      idt = $urandom; ddt = $urandom;
      if (ie) q_i.push_back(model[ik]);
      if (de) q_d.push_back(model[dk]);
      for (int b = 0; b < 4; b++) begin
        if (ie && iw[b]) model[ik][8*b +: 8] = idt[8*b +: 8];
        if (de && dw[b]) model[dk][8*b +: 8] = ddt[8*b +: 8];
      end
      drive(ie, iw, BASE + 32'h100 + 32'(4 * ik) + 32'($urandom_range(0, 3)), idt,
            de, dw, BASE + 32'h100 + 32'(4 * dk), ddt);
      if (ie) begin
        exp = q_i.pop_front(); checks++;
        if (inst_sram_rdata !== exp) begin errors++; $display("FAIL random[%0d] inst_rdata: got %h want %h", n, inst_sram_rdata, exp); end
      end
      if (de) begin
        exp = q_d.pop_front(); checks++;
        if (data_sram_rdata !== exp) begin errors++; $display("FAIL random[%0d] data_rdata: got %h want %h", n, data_sram_rdata, exp); end
      end
    end
  endtask

  task automatic test_async_reset();
    drive(0, 4'h0, BASE, 0, 1, 4'hF, BASE + 32'h50, 32'h5A5A_5A5A);
    drive(1, 4'h0, BASE + 32'h50, 0, 1, 4'h0, BASE + 32'h50, 0);
    #3 rst = 1'b1;
    #1;
    checks++; if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL async_rst inst_rdata: got %h want 0", inst_sram_rdata); end
    checks++; if (data_sram_rdata !== 32'h0) begin errors++; $display("FAIL async_rst data_rdata: got %h want 0", data_sram_rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_rst err: got %b want 0", err); end
    // Writes attempted under reset must be dropped.
    inst_sram_en = 1'b1; inst_sram_wen = 4'hF; inst_sram_addr = BASE + 32'h50; inst_sram_wdata = 32'h0;
    data_sram_en = 1'b1; data_sram_wen = 4'hF; data_sram_addr = BASE + 32'h50; data_sram_wdata = 32'h0;
    @(posedge clk); #1;
    checks++; if (inst_sram_rdata !== 32'h0) begin errors++; $display("FAIL in_rst inst_rdata: got %h want 0", inst_sram_rdata); end
    inst_sram_en = 1'b0; data_sram_en = 1'b0; inst_sram_wen = 4'h0; data_sram_wen = 4'h0;
    rst = 1'b0;
    q_i.push_back(32'h5A5A_5A5A);
    q_d.push_back(32'h5A5A_5A5A);
    drive(1, 4'h0, BASE + 32'h50, 0, 1, 4'h0, BASE + 32'h50, 0);
    exp = q_i.pop_front(); checks++;
    if (inst_sram_rdata !== exp) begin errors++; $display("FAIL post_rst inst_rdata: got %h want %h", inst_sram_rdata, exp); end
    exp = q_d.pop_front(); checks++;
    if (data_sram_rdata !== exp) begin errors++; $display("FAIL post_rst data_rdata: got %h want %h", data_sram_rdata, exp); end
  endtask

  task automatic test_range();
    drive(0, 4'h0, BASE, 0, 1, 4'hF, BASE, 32'h0BAD_0000);
`ifdef SRAM_RESP_ERR_EN
    q_i.push_back(POISON_WORD);
    q_d.push_back(POISON_WORD);
    drive(1, 4'hF, BASE + 2 * SPAN, 32'h77, 1, 4'hF, BASE + SPAN, 32'h99);
    exp = q_i.pop_front(); checks++;
    if (inst_sram_rdata !== exp) begin errors++; $display("FAIL oor inst_rdata: got %h want %h", inst_sram_rdata, exp); end
    exp = q_d.pop_front(); checks++;
    if (data_sram_rdata !== exp) begin errors++; $display("FAIL oor data_rdata: got %h want %h", data_sram_rdata, exp); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor err: got %b want 1", err); end
    checks++; if (err_addr !== BASE + SPAN) begin errors++; $display("FAIL oor err_addr: got %h want %h", err_addr, BASE + SPAN); end
    q_i.push_back(POISON_WORD);
    q_d.push_back(32'h0BAD_0000);
    drive(1, 4'h0, BASE - 32'h4, 0, 1, 4'h0, BASE, 0);
    exp = q_i.pop_front(); checks++;
    if (inst_sram_rdata !== exp) begin errors++; $display("FAIL oor_below inst_rdata: got %h want %h", inst_sram_rdata, exp); end
    exp = q_d.pop_front(); checks++;
    if (data_sram_rdata !== exp) begin errors++; $display("FAIL oor_no_write word0: got %h want %h", data_sram_rdata, exp); end
    checks++; if (err_addr !== BASE + SPAN) begin errors++; $display("FAIL oor_sticky err_addr: got %h want %h", err_addr, BASE + SPAN); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_sticky err: got %b want 1", err); end
`else
    drive(0, 4'h0, BASE, 0, 1, 4'hF, BASE + SPAN + 32'h8, 32'h0A11_A5ED);
    q_i.push_back(32'h0A11_A5ED);
    q_d.push_back(32'h0BAD_0000);
    drive(1, 4'h0, BASE + 32'h8, 0, 1, 4'h0, BASE + 3 * SPAN, 0);
    exp = q_i.pop_front(); checks++;
    if (inst_sram_rdata !== exp) begin errors++; $display("FAIL alias inst_rdata: got %h want %h", inst_sram_rdata, exp); end
    exp = q_d.pop_front(); checks++;
    if (data_sram_rdata !== exp) begin errors++; $display("FAIL alias data_rdata: got %h want %h", data_sram_rdata, exp); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL alias err: got %b want 0", err); end
    checks++; if (err_addr !== 32'h0) begin errors++; $display("FAIL alias err_addr: got %h want 0", err_addr); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_read_first();
    test_collision();
    test_random();
    test_async_reset();
    test_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
